// File: rtl/combat_arbiter_pkg.sv
// Shared types and defaults for the combat arbiter: FSM states, player ids,
// the 8-bit stat type and a saturating subtract helper.
package combat_arbiter_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned MAX_HEALTH_DEF = 15;
  localparam int unsigned MAX_SHIELD_DEF = 15;

  typedef logic [DATA_W-1:0] stat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    OVER  = 2'd2
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  function automatic stat_t sat_sub(input stat_t a, input stat_t b);
    return (a >= b) ? stat_t'(a - b) : '0;
  endfunction

endpackage

// File: rtl/combat_arbiter_if.sv
// Player/renderer-facing signal bundle of the combat arbiter.
// master = game side driving requests, slave = the arbiter.
interface combat_arbiter_if;

  logic                      round_restart;
  logic                      p1_attack_req;
  logic                      p2_attack_req;
  logic                      p1_shield_active;
  logic                      p2_shield_active;
  logic                      in_range;
  combat_arbiter_pkg::stat_t p1_health;
  combat_arbiter_pkg::stat_t p2_health;
  combat_arbiter_pkg::stat_t p1_shield;
  combat_arbiter_pkg::stat_t p2_shield;
  logic                      p1_ready;
  logic                      p2_ready;
  logic                      p1_hit;
  logic                      p2_hit;
  logic                      p1_blocked;
  logic                      p2_blocked;
  logic                      busy;
  logic                      game_over;
  logic                      winner;

  modport master (
    output round_restart, p1_attack_req, p2_attack_req,
           p1_shield_active, p2_shield_active, in_range,
    input  p1_health, p2_health, p1_shield, p2_shield, p1_ready, p2_ready,
           p1_hit, p2_hit, p1_blocked, p2_blocked, busy, game_over, winner
  );

  modport slave (
    input  round_restart, p1_attack_req, p2_attack_req,
           p1_shield_active, p2_shield_active, in_range,
    output p1_health, p2_health, p1_shield, p2_shield, p1_ready, p2_ready,
           p1_hit, p2_hit, p1_blocked, p2_blocked, busy, game_over, winner
  );

endinterface

// File: rtl/combat_arbiter_cooldown.sv
// Per-player attack cooldown: loads on grant, counts down to zero and holds.
module combat_arbiter_cooldown #(
  parameter int unsigned COOLDOWN = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int unsigned CW = $clog2(COOLDOWN + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(COOLDOWN);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/combat_arbiter.sv
// Owns both players' health/shield, serializes attack requests round-robin,
// resolves hits against range and shield, regenerates shields, detects game over.
module combat_arbiter
  import combat_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = MAX_HEALTH_DEF,
  parameter int unsigned MAX_SHIELD    = MAX_SHIELD_DEF,
  parameter int unsigned ATTACK_DAMAGE = 3,
  parameter int unsigned SHIELD_COST   = 2,
  parameter int unsigned COOLDOWN      = 25_000_000,
  parameter int unsigned REGEN_PERIOD  = 50_000_000
) (
  input logic              clk,
  input logic              reset,
  combat_arbiter_if.slave  bus
);

  localparam int unsigned RW = $clog2(REGEN_PERIOD);

  state_t          state_q, state_d;
  player_t         last_q, last_d, atk_q, atk_d;
  logic            rng_q, rng_d, shs_q, shs_d, winner_q, winner_d;
  logic [1:0]      pend_q, pend_d, hit_q, hit_d, blk_q, blk_d;
  stat_t [1:0]     health_q, health_d, shield_q, shield_d;
  logic [RW-1:0]   regen_q, regen_d;

  logic [1:0]      req, shact, cd_zero;
  logic            restart, any_pend, grant, regen_wrap;
  logic            blocked_now, hit_now;
  player_t         gsel, def;
  stat_t           new_health, new_shield;

  assign req      = {bus.p2_attack_req, bus.p1_attack_req};
  assign shact    = {bus.p2_shield_active, bus.p1_shield_active};
  assign restart  = bus.round_restart;
  assign any_pend = |pend_q;
  // A tie goes to whoever was not granted last.
  assign gsel     = (&pend_q) ? player_t'(~last_q) : (pend_q[0] ? P1 : P2);
  assign grant    = (state_q == IDLE) && any_pend;
  assign def      = player_t'(~atk_q);

  assign blocked_now = (state_q == APPLY) && rng_q && shs_q && (shield_q[def] != '0);
  assign hit_now     = (state_q == APPLY) && rng_q && !blocked_now;
  assign new_health  = sat_sub(health_q[def], stat_t'(ATTACK_DAMAGE));
  assign new_shield  = sat_sub(shield_q[def], stat_t'(SHIELD_COST));
  assign regen_wrap  = (regen_q == RW'(REGEN_PERIOD - 1));

  combat_arbiter_cooldown #(.COOLDOWN(COOLDOWN)) u_cd_p1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (restart),
    .load_i  (grant && (gsel == P1)),
    .en_i    (state_q != OVER),
    .zero_o  (cd_zero[0])
  );

  combat_arbiter_cooldown #(.COOLDOWN(COOLDOWN)) u_cd_p2 (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (restart),
    .load_i  (grant && (gsel == P2)),
    .en_i    (state_q != OVER),
    .zero_o  (cd_zero[1])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_pend) state_d = APPLY;
      APPLY:   state_d = (hit_now && (new_health == '0)) ? OVER : IDLE;
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
    if (restart) state_d = IDLE;
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.game_over = (state_q == OVER);
  end

  always_comb begin
    pend_d   = pend_q;
    last_d   = last_q;
    atk_d    = atk_q;
    rng_d    = rng_q;
    shs_d    = shs_q;
    winner_d = winner_q;
    health_d = health_q;
    shield_d = shield_q;
    regen_d  = regen_q;
    hit_d    = '0;
    blk_d    = '0;
    if (state_q != OVER) begin
      regen_d = regen_wrap ? '0 : regen_q + 1'b1;
      for (int unsigned p = 0; p < 2; p++) begin
        if (regen_wrap && !shact[p] && (shield_q[p] < stat_t'(MAX_SHIELD)))
          shield_d[p] = shield_q[p] + 1'b1;
        if (req[p] && !pend_q[p] && cd_zero[p])
          pend_d[p] = 1'b1;
      end
      if (grant) begin
        pend_d[gsel] = 1'b0;
        atk_d        = gsel;
        last_d       = gsel;
        rng_d        = bus.in_range;
        shs_d        = (gsel == P1) ? shact[1] : shact[0];
      end
      // Written after regen so a block on the wrap edge overrides that tick.
      if (blocked_now) begin
        shield_d[def] = new_shield;
        blk_d[def]    = 1'b1;
      end
      if (hit_now) begin
        health_d[def] = new_health;
        hit_d[def]    = 1'b1;
        if (new_health == '0) winner_d = atk_q;
      end
    end
    if (state_d == OVER) pend_d = '0;
    if (restart) begin
      pend_d   = '0;
      last_d   = P2;
      atk_d    = P1;
      rng_d    = 1'b0;
      shs_d    = 1'b0;
      winner_d = 1'b0;
      health_d = {2{stat_t'(MAX_HEALTH)}};
      shield_d = {2{stat_t'(MAX_SHIELD)}};
      regen_d  = '0;
      hit_d    = '0;
      blk_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= '0;
      last_q   <= P2;
      atk_q    <= P1;
      rng_q    <= 1'b0;
      shs_q    <= 1'b0;
      winner_q <= 1'b0;
      health_q <= {2{stat_t'(MAX_HEALTH)}};
      shield_q <= {2{stat_t'(MAX_SHIELD)}};
      regen_q  <= '0;
      hit_q    <= '0;
      blk_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      last_q   <= last_d;
      atk_q    <= atk_d;
      rng_q    <= rng_d;
      shs_q    <= shs_d;
      winner_q <= winner_d;
      health_q <= health_d;
      shield_q <= shield_d;
      regen_q  <= regen_d;
      hit_q    <= hit_d;
      blk_q    <= blk_d;
    end
  end

  assign bus.p1_health  = health_q[0];
  assign bus.p2_health  = health_q[1];
  assign bus.p1_shield  = shield_q[0];
  assign bus.p2_shield  = shield_q[1];
  assign bus.p1_ready   = cd_zero[0] && !pend_q[0];
  assign bus.p2_ready   = cd_zero[1] && !pend_q[1];
  assign bus.p1_hit     = hit_q[0];
  assign bus.p2_hit     = hit_q[1];
  assign bus.p1_blocked = blk_q[0];
  assign bus.p2_blocked = blk_q[1];
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// Bench for combat_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the game rules.
module tb_combat_arbiter;

  localparam int MAXH = 15, MAXS = 15, DMG = 3, COST = 2, CD = 4, REGEN = 8;

  logic clk, reset;
  combat_arbiter_if bus();

  combat_arbiter #(
    .MAX_HEALTH(MAXH), .MAX_SHIELD(MAXS), .ATTACK_DAMAGE(DMG),
    .SHIELD_COST(COST), .COOLDOWN(CD), .REGEN_PERIOD(REGEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pending hit waiting to be resolved one cycle after it was granted.
  int  m_h[2], m_s[2], m_cd[2], m_last, m_atk, m_win, m_regen;
  bit  m_pend[2], m_hit[2], m_blk[2], m_fly, m_rng, m_shs, m_over;
  bit  sh[2];
  bit  rng;

  function automatic void model_init();
    for (int p = 0; p < 2; p++) begin
      m_h[p] = MAXH; m_s[p] = MAXS; m_cd[p] = 0;
      m_pend[p] = 0; m_hit[p] = 0; m_blk[p] = 0;
    end
    m_last = 1; m_atk = 0; m_win = 0; m_regen = 0;
    m_fly = 0; m_rng = 0; m_shs = 0; m_over = 0;
  endfunction

  function automatic void model_step(input bit r0, input bit r1, input bit rr);
    bit pend0[2];
    int cd0[2];
    bit sh_written[2];
    bit req[2];
    int g;
    bit granted;
    if (rr) begin
      model_init();
      return;
    end
    m_hit = '{0, 0};
    m_blk = '{0, 0};
    if (m_over) return;
    req = '{r0, r1};
    pend0 = m_pend;
    cd0 = m_cd;
    sh_written = '{0, 0};
    granted = 0;
    g = 0;
    if (m_fly) begin
      int d = 1 - m_atk;
      m_fly = 0;
      if (m_rng) begin
        if (m_shs && m_s[d] > 0) begin
          m_s[d] = (m_s[d] > COST) ? m_s[d] - COST : 0;
          m_blk[d] = 1;
          sh_written[d] = 1;
        end else begin
          m_h[d] = (m_h[d] > DMG) ? m_h[d] - DMG : 0;
          m_hit[d] = 1;
          if (m_h[d] == 0) begin
            m_over = 1;
            m_win = m_atk;
          end
        end
      end
    end else if (m_pend[0] || m_pend[1]) begin
      g = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
      granted = 1;
      m_fly = 1; m_atk = g; m_last = g;
      m_rng = rng; m_shs = sh[1 - g];
      m_pend[g] = 0;
    end
    if (m_regen == REGEN - 1) begin
      m_regen = 0;
      for (int p = 0; p < 2; p++)
        if (!sh_written[p] && !sh[p] && m_s[p] < MAXS) m_s[p]++;
    end else begin
      m_regen++;
    end
    for (int p = 0; p < 2; p++) begin
      if (granted && g == p) m_cd[p] = CD;
      else if (m_cd[p] > 0) m_cd[p]--;
      if (req[p] && !pend0[p] && cd0[p] == 0) m_pend[p] = 1;
    end
    if (m_over) m_pend = '{0, 0};
  endfunction

  task automatic compare_all();
    check("p1_health", int'(bus.p1_health), m_h[0]);
    check("p2_health", int'(bus.p2_health), m_h[1]);
    check("p1_shield", int'(bus.p1_shield), m_s[0]);
    check("p2_shield", int'(bus.p2_shield), m_s[1]);
    check("p1_ready", int'(bus.p1_ready), int'(m_cd[0] == 0 && !m_pend[0]));
    check("p2_ready", int'(bus.p2_ready), int'(m_cd[1] == 0 && !m_pend[1]));
    check("p1_hit", int'(bus.p1_hit), int'(m_hit[0]));
    check("p2_hit", int'(bus.p2_hit), int'(m_hit[1]));
    check("p1_blocked", int'(bus.p1_blocked), int'(m_blk[0]));
    check("p2_blocked", int'(bus.p2_blocked), int'(m_blk[1]));
    check("busy", int'(bus.busy), int'(m_fly || m_over));
    check("game_over", int'(bus.game_over), int'(m_over));
    check("winner", int'(bus.winner), m_win);
  endtask

  task automatic tick(input bit r0, input bit r1, input bit rr);
    bus.p1_attack_req    = r0;
    bus.p2_attack_req    = r1;
    bus.round_restart    = rr;
    bus.p1_shield_active = sh[0];
    bus.p2_shield_active = sh[1];
    bus.in_range         = rng;
    @(posedge clk);
    model_step(r0, r1, rr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    sh = '{0, 0};
    rng = 1'b1;
    bus.p1_attack_req = 0; bus.p2_attack_req = 0; bus.round_restart = 0;
    bus.p1_shield_active = 0; bus.p2_shield_active = 0; bus.in_range = 1;
    model_init();
    #16;
    compare_all();
    check("rst_p1_health", int'(bus.p1_health), 15);
    check("rst_p2_shield", int'(bus.p2_shield), 15);
    reset = 1'b0;

    // Single in-range hit on an unshielded P2.
    tick(1, 0, 0);
    tick(0, 0, 0);
    check("e1_busy", int'(bus.busy), 1);
    tick(0, 0, 0);
    check("e2_p2_health", int'(bus.p2_health), 12);
    check("e2_p2_hit", int'(bus.p2_hit), 1);
    tick(0, 0, 0);
    check("e3_p2_hit_clear", int'(bus.p2_hit), 0);
    check("e3_busy", int'(bus.busy), 0);
    idle(6);

    // Tie after restart: P1 first, then P2.
    tick(0, 0, 1);
    tick(1, 1, 0);
    idle(2);
    check("tie_e2_p2", int'(bus.p2_health), 12);
    check("tie_e2_p1", int'(bus.p1_health), 15);
    idle(2);
    check("tie_e4_p1", int'(bus.p1_health), 12);
    idle(6);
    tick(1, 0, 0);
    idle(7);
    // Last grant was P1, so this tie starts with P2.
    tick(1, 1, 0);
    idle(2);
    check("tie2_e2_p1", int'(bus.p1_health), 9);
    check("tie2_e2_p2", int'(bus.p2_health), 9);
    idle(2);
    check("tie2_e4_p2", int'(bus.p2_health), 6);
    idle(6);

    // Drain P2 shield to 1, then block to 0, then take health damage.
    tick(0, 0, 1);
    sh[1] = 1;
    for (int k = 0; k < 7; k++) begin
      tick(1, 0, 0);
      idle(7);
    end
    check("drain_p2_shield", int'(bus.p2_shield), 1);
    tick(1, 0, 0);
    idle(1);
    tick(0, 0, 0);
    check("blk_floor_shield", int'(bus.p2_shield), 0);
    check("blk_pulse", int'(bus.p2_blocked), 1);
    idle(5);
    tick(1, 0, 0);
    idle(2);
    check("shield0_hit_health", int'(bus.p2_health), 12);
    check("shield0_hit_pulse", int'(bus.p2_hit), 1);
    sh[1] = 0;
    idle(6);

    // Second request two cycles after the first is dropped.
    tick(0, 0, 1);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    idle(10);
    check("drop_once", int'(bus.p2_health), 12);

    // Knock P2 out, verify OVER holds, then restart.
    tick(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0);
      idle(7);
    end
    check("over_health", int'(bus.p2_health), 0);
    check("over_flag", int'(bus.game_over), 1);
    check("over_winner", int'(bus.winner), 0);
    tick(1, 1, 0);
    idle(8);
    check("over_hold_p1", int'(bus.p1_health), 15);
    tick(0, 0, 1);
    check("restart_p2_health", int'(bus.p2_health), 15);
    check("restart_over", int'(bus.game_over), 0);

    // P1 shield down to 9 by blocks, then regen back to the cap.
    sh[0] = 1;
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0);
      idle(7);
    end
    check("regen_start", int'(bus.p1_shield), 9);
    sh[0] = 0;
    idle(60);
    check("regen_cap", int'(bus.p1_shield), 15);

    // Reset during APPLY, after an earlier hit.
    tick(1, 0, 0);
    idle(7);
    tick(1, 0, 0);
    tick(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_init();
    compare_all();
    check("midapply_p2_health", int'(bus.p2_health), 15);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r0, r1, rr;
      if (i % 16 == 0) begin
        sh[0] = 1'($urandom_range(0, 1));
        sh[1] = 1'($urandom_range(0, 1));
        rng   = ($urandom_range(0, 3) != 0);
      end
      r0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 3) == 0);
      rr = m_over ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      tick(r0, r1, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
